prog_loader: RTL

//  Byte-stream program loader upstream of the ram block. Parses framed bytes from a serial

---
 rtl/prog_loader_if.sv | 28 ++
 rtl/prog_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream handshake and memory write bus between a serial receiver, the
// program loader and the ram block.
interface prog_loader_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    // Upstream side: the byte source that also observes loader status.
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_wdata, mem_we, cpu_hold, done, err, err_code
    );

    // Loader side.
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_wdata, mem_we, cpu_hold, done, err, err_code
    );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: SYNC, ADDR_H, ADDR_L, LEN, DATA x N, [CKSUM].
// Define PROG_LOADER_CKSUM_EN to require and check the trailing checksum byte.
module prog_loader #(
    parameter int          ADDR_W    = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 50000
) (
    input  logic        clk,
    input  logic        rst,
    prog_loader_if.slave bus
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        AH,
        AL,
        LEN,
        DATA,
        WR,
`ifdef PROG_LOADER_CKSUM_EN
        CKS,
`endif
        DONE,
        ERR
    } state_t;

    state_t            state;
    logic [7:0]        addr_h;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        wdata;
    logic [8:0]        count;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              rx_ready_q;
    logic              mem_we_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        err_code_q;
`ifdef PROG_LOADER_CKSUM_EN
    logic [7:0]        sum;
`endif

    logic accept;
    logic counting;
    logic tmo_hit;

    assign accept = bus.rx_valid & rx_ready_q;

    // The inter-byte timeout only runs while a frame is waiting for its next byte.
    always_comb begin
        counting = (state == AH) || (state == AL) || (state == LEN) || (state == DATA);
`ifdef PROG_LOADER_CKSUM_EN
        if (state == CKS) counting = 1'b1;
`endif
    end

    assign tmo_hit = counting && !accept && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_h     <= '0;
            cur_addr   <= '0;
            wdata      <= '0;
            count      <= '0;
            tmo_cnt    <= '0;
            rx_ready_q <= 1'b1;
            mem_we_q   <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
`ifdef PROG_LOADER_CKSUM_EN
            sum        <= '0;
`endif
        end else begin
            done_q   <= 1'b0;
            mem_we_q <= 1'b0;

            if (counting && !accept) tmo_cnt <= tmo_cnt + 1'b1;
            else                     tmo_cnt <= '0;

`ifdef PROG_LOADER_CKSUM_EN
            if (accept && state != IDLE) sum <= sum + bus.rx_data;
`endif

            if (tmo_hit) begin
                state      <= ERR;
                err_q      <= 1'b1;
                err_code_q <= 2'b01;
                cpu_hold_q <= 1'b0;
                rx_ready_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept && bus.rx_data == SYNC_BYTE) begin
                            state      <= AH;
                            cpu_hold_q <= 1'b1;
                            err_q      <= 1'b0;
                            err_code_q <= 2'b00;
`ifdef PROG_LOADER_CKSUM_EN
                            sum        <= '0;
`endif
                        end
                    end
                    AH: begin
                        if (accept) begin
                            addr_h <= bus.rx_data;
                            state  <= AL;
                        end
                    end
                    AL: begin
                        if (accept) begin
                            cur_addr <= ADDR_W'({addr_h, bus.rx_data});
                            state    <= LEN;
                        end
                    end
                    LEN: begin
                        if (accept) begin
                            // A zero length byte stands for a full 256-byte block.
                            count <= (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (accept) begin
                            wdata      <= bus.rx_data;
                            mem_we_q   <= 1'b1;
                            rx_ready_q <= 1'b0;
                            state      <= WR;
                        end
                    end
                    WR: begin
                        cur_addr <= cur_addr + 1'b1;
                        count    <= count - 1'b1;
                        if (count == 9'd1) begin
`ifdef PROG_LOADER_CKSUM_EN
                            state      <= CKS;
                            rx_ready_q <= 1'b1;
`else
                            state      <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
`endif
                        end else begin
                            state      <= DATA;
                            rx_ready_q <= 1'b1;
                        end
                    end
`ifdef PROG_LOADER_CKSUM_EN
                    CKS: begin
                        if (accept) begin
                            rx_ready_q <= 1'b0;
                            cpu_hold_q <= 1'b0;
                            if (8'(sum + bus.rx_data) == 8'h00) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                state      <= ERR;
                                err_q      <= 1'b1;
                                err_code_q <= 2'b10;
                            end
                        end
                    end
`endif
                    DONE: begin
                        state      <= IDLE;
                        rx_ready_q <= 1'b1;
                    end
                    ERR: begin
                        state      <= IDLE;
                        rx_ready_q <= 1'b1;
                    end
                    default: begin
                        state      <= IDLE;
                        rx_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_addr  = cur_addr;
    assign bus.mem_wdata = wdata;
    assign bus.mem_we    = mem_we_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;

endmodule
